// File: rtl/comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM state encoding
// and the digit-count / digit-index-width derivation.
package comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of DIGIT-bit slices in a WIDTH-bit operand.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Bits needed to hold a digit index 0..NDIG-1 (never narrower than 1 bit).
  function automatic int calc_idx_w(input int width, input int digit);
    int n;
    n = width / digit;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_comparator_digit.sv
// Combinational compare of one DIGIT-bit slice, both slices taken as unsigned.
module digit_compare #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_o,
  output logic         gt_o
);

  // Slice ordering: equality and strict greater-than of A over B.
  always_comb begin
    eq_o = (a_i == b_i);
    gt_o = (a_i > b_i);
  end

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator. Latches two operands on start, walks
// the digits MSB slice first and stops at the first differing slice.
//
// state | meaning
// IDLE  | waiting for start_i, result flags hold the last outcome
// BUSY  | comparing the slice selected by idx_q
// DONE  | one-cycle done_o pulse, fresh result flags valid
import comparator_pkg::*;

module serial_comparator #(
  parameter int WIDTH = 10,
  parameter int DIGIT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             equal_o,
  output logic             greater_o,
  output logic             lesser_o
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int IW    = calc_idx_w(WIDTH, DIGIT);
  localparam int NSLOT = 2 ** IW;

  localparam logic [IW-1:0]    IDX_TOP  = IW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [IW-1:0]    idx_q;
  logic             busy_q;
  logic             done_q;
  logic             eq_q;
  logic             gt_q;
  logic             lt_q;

  // Operands viewed as an array of slices; slots past NDIG exist only so the
  // index width matches the array exactly and read as zero.
  logic [DIGIT-1:0] a_dig [NSLOT];
  logic [DIGIT-1:0] b_dig [NSLOT];
  logic [DIGIT-1:0] a_sl;
  logic [DIGIT-1:0] b_sl;
  logic             dig_eq;
  logic             dig_gt;

  for (genvar s = 0; s < NSLOT; s++) begin : g_slot
    if (s < NDIG) begin : g_used
      assign a_dig[s] = a_q[s*DIGIT +: DIGIT];
      assign b_dig[s] = b_q[s*DIGIT +: DIGIT];
    end else begin : g_pad
      assign a_dig[s] = '0;
      assign b_dig[s] = '0;
    end
  end

  // Select the slice under examination.
  always_comb begin
    a_sl = a_dig[idx_q];
    b_sl = b_dig[idx_q];
  end

  digit_compare #(
    .W (DIGIT)
  ) u_digit_compare (
    .a_i  (a_sl),
    .b_i  (b_sl),
    .eq_o (dig_eq),
    .gt_o (dig_gt)
  );

  // Sequencing FSM with registered status and result flags. Signed operands
  // get their MSB flipped at capture, which maps two's-complement order onto
  // unsigned order so the slice walk is mode-agnostic.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= signed_i ? (a_i ^ MSB_MASK) : a_i;
            b_q     <= signed_i ? (b_i ^ MSB_MASK) : b_i;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!dig_eq) begin
            eq_q    <= 1'b0;
            gt_q    <= dig_gt;
            lt_q    <= !dig_gt;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (idx_q == '0) begin
            eq_q    <= 1'b1;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign equal_o   = eq_q;
  assign greater_o = gt_q;
  assign lesser_o  = lt_q;

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 10, operand width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 1, bits compared per cycle; WIDTH SHALL be an integer multiple of DIGIT, and violation SHALL be an elaboration error.
REQ-003 Clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Rst_i  input  1  reset, synchronous and active-high.
REQ-005 Start_i  input  1  request to compare; sampled only in IDLE.
REQ-006 Signed_i  input  1  1 = two's-complement compare, 0 = unsigned; sampled with Start_i.
REQ-007 A_i  input  WIDTH  operand A; sampled with Start_i.
REQ-008 B_i  input  WIDTH  operand B; sampled with Start_i.
REQ-009 Busy_o  output  1  high in BUSY and DONE.
REQ-010 Done_o  output  1  one-cycle pulse marking valid results.
REQ-011 Equal_o / Greater_o / Lesser_o  output  1 each  registered result flags: A==B, A>B and A<B respectively.

Function
REQ-012 The block SHALL use three states: IDLE, BUSY and DONE; NDIG = WIDTH/DIGIT.
REQ-013 In IDLE with Start_i=1, the block SHALL latch A_i, B_i and Signed_i, set digit index to NDIG-1, and enter BUSY at the next edge.
REQ-014 In signed mode, the MSB of both latched operands SHALL be inverted before comparison; no other bits are altered.
REQ-015 Each BUSY cycle SHALL compare exactly one DIGIT-bit slice at the current index, MSB slice first, as unsigned values.
REQ-016 If the slices differ, the block SHALL register Greater_o/Lesser_o from the slice ordering, set Equal_o=0, and enter DONE (early termination).
REQ-017 If the slices are equal and the index is 0, the block SHALL register Equal_o=1 with Greater_o=Lesser_o=0 and enter DONE.
REQ-018 If the slices are equal and the index is >0, the block SHALL decrement the index and remain in BUSY.
REQ-019 Latency SHALL be k+1 cycles from the Start_i sampling edge to the Done_o high cycle, where k (1..NDIG) is the number of digits examined.
REQ-020 DONE SHALL last exactly one cycle with Done_o=1, then return to IDLE.
REQ-021 Start_i in BUSY or DONE SHALL be ignored, with no queuing; a new Start_i is first accepted in the cycle after DONE.
REQ-022 Result flags SHALL hold their value from the Done_o cycle until the next DONE or reset.
REQ-023 Exactly one result flag SHALL be high at any time after the first completion; all three SHALL be 0 before it.
REQ-024 Changes on A_i, B_i or Signed_i during BUSY SHALL NOT affect the result in progress.

Reset
REQ-025 Rst_i=1 at an edge SHALL force IDLE with Busy_o, Done_o, Equal_o, Greater_o and Lesser_o all 0, clear the latched operands and set the index to 0, from any state.
REQ-026 Reset mid-BUSY SHALL abort the comparison without asserting Done_o; Start_i in the cycle Rst_i deasserts SHALL be accepted.

Structure
REQ-027 The state encoding (IDLE=0, BUSY=1, DONE=2) and the NDIG/index-width derivation SHALL live in shared package comparator_pkg.
REQ-028 The slice compare SHALL be one combinational sub-module, digit_compare (DIGIT-bit inputs; outputs eq, gt), instantiated once.
REQ-029 The operand registers, index counter and FSM SHALL reside in serial_comparator; the design SHALL have no latches and no combinational path from inputs to outputs.

Verification
REQ-030 WIDTH=10, DIGIT=1, unsigned, A=B=0x2AA -> Done_o on cycle 11 after start, Equal_o=1.
REQ-031 WIDTH=10, DIGIT=1, unsigned, A=0x200, B=0x1FF -> Done_o on cycle 2, Greater_o=1; same operands with Signed_i=1 -> Lesser_o=1.
REQ-032 WIDTH=10, DIGIT=2, unsigned, A=0x003, B=0x002 -> 5 digits examined, Done_o on cycle 6, Greater_o=1.
REQ-033 Start_i held high continuously through 3 back-to-back compares -> each start accepted only in IDLE, spaced by a DONE cycle, and A_i/B_i toggled mid-BUSY do not alter results.
REQ-034 Rst_i pulse at cycle 4 of a 10-digit equal compare -> no Done_o, all outputs 0 next cycle, and a new compare started immediately completes correctly.
REQ-035 Random regression of 10k operand pairs over WIDTH in {8,10,16} and DIGIT in {1,2,4}, both modes -> flags match a reference-model compare and the latency matches REQ-019.
